// File: rtl/legv8_mc_ctrl.sv
// legv8_mc_ctrl -- multi-cycle control sequencer for the LEGv8 datapath.
//
// Steps each instruction through FETCH / DECODE / EXEC / MEM / WB and drives
// the datapath controls for each step. Instruction fetch and data access
// share one memory port, which uses a req/ack handshake.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   opcode[10:0]    instr[31:21], valid once ir_write has been applied
//   zero            ALU zero flag, used by CBZ in EXEC
//   mem_ack         memory completes the outstanding request this cycle
//   mem_req/mem_we/mem_is_data   memory request, write strobe, data/instr select
//   ir_write, pc_write, pc_src   IR latch, PC update pulse, PC source select
//   seu_sel[1:0]    sign-extend format select
//   alu_src, alu_op, reg2_loc    ALU operand and function select
//   reg_write, mem_to_reg        register-file write pulse and source select
//   halted          sticky flag raised by an illegal opcode
//   retired         retired-instruction count (LEGV8_MC_CTRL_PERF_EN only)
//
// Optional feature: define LEGV8_MC_CTRL_PERF_EN to add the PERF_W-bit
// retired-instruction counter.
//
// Every output is decoded from the registered state, the latched
// instruction class and the live inputs. All outputs are forced low while
// rst_n is low, so no request or pulse can leak out during reset.
module legv8_mc_ctrl #(
  parameter int ALU_OP_W = 2,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [10:0]         opcode,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_is_data,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          seu_sel,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg2_loc,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                halted
`ifdef LEGV8_MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]   retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LDUR, C_STUR, C_B, C_CBZ, C_ILL
  } cls_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam logic [ALU_OP_W-1:0] AOP_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] AOP_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] AOP_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] AOP_ORR = ALU_OP_W'(3);

  state_e               state_q, state_d;
  cls_e                 cls_q, dec_cls;
  logic [ALU_OP_W-1:0]  aop_q, dec_aop;

  // Opcode classification; only meaningful in DECODE, latched on exit.
  always_comb begin
    dec_cls = C_ILL;
    dec_aop = AOP_ADD;
    if (opcode == OP_ADD) begin
      dec_cls = C_R;    dec_aop = AOP_ADD;
    end else if (opcode == OP_SUB) begin
      dec_cls = C_R;    dec_aop = AOP_SUB;
    end else if (opcode == OP_AND) begin
      dec_cls = C_R;    dec_aop = AOP_AND;
    end else if (opcode == OP_ORR) begin
      dec_cls = C_R;    dec_aop = AOP_ORR;
    end else if (opcode[10:1] == OP_ADDI) begin
      dec_cls = C_I;    dec_aop = AOP_ADD;
    end else if (opcode[10:1] == OP_SUBI) begin
      dec_cls = C_I;    dec_aop = AOP_SUB;
    end else if (opcode == OP_LDUR) begin
      dec_cls = C_LDUR;
    end else if (opcode == OP_STUR) begin
      dec_cls = C_STUR;
    end else if (opcode[10:5] == OP_B) begin
      dec_cls = C_B;
    end else if (opcode[10:3] == OP_CBZ) begin
      dec_cls = C_CBZ;
    end
  end

  function automatic logic [1:0] seu_of(input cls_e c);
    case (c)
      C_LDUR, C_STUR: seu_of = 2'b01;
      C_B:            seu_of = 2'b10;
      C_CBZ:          seu_of = 2'b11;
      default:        seu_of = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      aop_q   <= AOP_ADD;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
        aop_q <= dec_aop;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_data = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    seu_sel     = 2'b00;
    alu_src     = 1'b0;
    alu_op      = AOP_ADD;
    reg2_loc    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Class register is not loaded yet, so drive seu_sel from the live decode.
        seu_sel = seu_of(dec_cls);
        state_d = (dec_cls == C_ILL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        seu_sel  = seu_of(cls_q);
        alu_op   = aop_q;
        alu_src  = (cls_q == C_I) || (cls_q == C_LDUR) || (cls_q == C_STUR);
        reg2_loc = (cls_q == C_STUR) || (cls_q == C_CBZ);
        case (cls_q)
          C_R, C_I:       state_d = S_WB;
          C_LDUR, C_STUR: state_d = S_MEM;
          C_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            state_d  = S_FETCH;
          end
          C_CBZ: begin
            // ALU passes Rt through; the datapath's zero flag decides the branch.
            pc_write = zero;
            pc_src   = 1'b1;
            state_d  = S_FETCH;
          end
          default:        state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        seu_sel     = seu_of(cls_q);
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = (cls_q == C_STUR);
        if (mem_ack)
          state_d = (cls_q == C_STUR) ? S_FETCH : S_WB;
      end
      S_WB: begin
        seu_sel    = seu_of(cls_q);
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LDUR);
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_is_data = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      seu_sel     = 2'b00;
      alu_src     = 1'b0;
      alu_op      = AOP_ADD;
      reg2_loc    = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      halted      = 1'b0;
    end
  end

`ifdef LEGV8_MC_CTRL_PERF_EN
  // Count on each instruction's last cycle: WB, branch EXEC, or STUR completion.
  logic retire;
  assign retire = (state_q == S_WB) ||
                  ((state_q == S_EXEC) && ((cls_q == C_B) || (cls_q == C_CBZ))) ||
                  ((state_q == S_MEM) && (cls_q == C_STUR) && mem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + PERF_W'(1);
  end
`else
  // PERF_W only sizes the optional counter.
  if (PERF_W < 1) begin : g_perf_w_unused
  end
`endif

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
module tb_legv8_mc_ctrl;

  localparam int PW = 4;

  logic        clk, rst_n;
  logic [10:0] opcode;
  logic        zero, mem_ack;
  logic        mem_req, mem_we, mem_is_data, ir_write, pc_write, pc_src;
  logic [1:0]  seu_sel;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        reg2_loc, reg_write, mem_to_reg, halted;
`ifdef LEGV8_MC_CTRL_PERF_EN
  logic [PW-1:0] retired;
`endif

  legv8_mc_ctrl #(.ALU_OP_W(2), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_data(mem_is_data),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .seu_sel(seu_sel), .alu_src(alu_src), .alu_op(alu_op),
    .reg2_loc(reg2_loc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .halted(halted)
`ifdef LEGV8_MC_CTRL_PERF_EN
    , .retired(retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_is_data;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] seu_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg2_loc;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halted;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {mem_req, mem_we, mem_is_data, ir_write, pc_write, pc_src,
                  seu_sel, alu_src, alu_op, reg2_loc, reg_write, mem_to_reg, halted};

  // One expected cycle: inputs to apply and the outputs they must produce.
  typedef struct {
    logic [10:0] op;
    logic        ack;
    logic        z;
    outs_t       exp;
    string       tag;
  } cyc_t;

  cyc_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] AND_ = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_B = 4, K_CBZ = 5, K_ILL = 6;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int kind_of(input logic [10:0] op);
    if (op == ADD || op == SUB || op == AND_ || op == ORR)      return K_R;
    if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100) return K_I;
    if (op == LDUR)                                               return K_LD;
    if (op == STUR)                                               return K_ST;
    if (op[10:5] == 6'b000101)                                    return K_B;
    if (op[10:3] == 8'b10110100)                                  return K_CBZ;
    return K_ILL;
  endfunction

  function automatic logic [1:0] aop_of(input logic [10:0] op);
    if (op == SUB || op[10:1] == 10'b1101000100) return 2'b01;
    if (op == AND_) return 2'b10;
    if (op == ORR)  return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] seu_for(input int k);
    case (k)
      K_LD, K_ST: return 2'b01;
      K_B:        return 2'b10;
      K_CBZ:      return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic push(input logic [10:0] op, input logic ack, input logic z,
                      input outs_t e, input string tag);
    cyc_t c;
    c.op = op; c.ack = ack; c.z = z; c.exp = e; c.tag = tag;
    q.push_back(c);
  endtask

  // Expected cycle trace for one instruction, built from the step-by-step
  // behaviour of each instruction class. Acks outside FETCH/MEM are random.
  task automatic build(input logic [10:0] op, input int fd, input int md);
    outs_t e;
    int    k = kind_of(op);
    logic  z;
    for (int i = 0; i < fd; i++) begin
      e = '0; e.mem_req = 1;
      push(op, 1'b0, rb(), e, "fetch_wait");
    end
    e = '0; e.mem_req = 1; e.ir_write = 1; e.pc_write = 1;
    push(op, 1'b1, rb(), e, "fetch_ack");
    e = '0; e.seu_sel = seu_for(k);
    push(op, rb(), rb(), e, "decode");
    if (k == K_ILL) begin
      for (int i = 0; i < 20; i++) begin
        e = '0; e.halted = 1;
        push(op, rb(), rb(), e, "halt");
      end
      return;
    end
    z = rb();
    e = '0;
    e.seu_sel  = seu_for(k);
    e.alu_op   = aop_of(op);
    e.alu_src  = (k == K_I || k == K_LD || k == K_ST);
    e.reg2_loc = (k == K_ST || k == K_CBZ);
    if (k == K_B)   begin e.pc_write = 1; e.pc_src = 1; end
    if (k == K_CBZ) begin e.pc_write = z; e.pc_src = 1; end
    push(op, rb(), z, e, "exec");
    if (k == K_B || k == K_CBZ) return;
    if (k == K_LD || k == K_ST) begin
      e = '0; e.seu_sel = 2'b01; e.mem_req = 1; e.mem_is_data = 1; e.mem_we = (k == K_ST);
      for (int i = 0; i < md; i++) push(op, 1'b0, rb(), e, "mem_wait");
      push(op, 1'b1, rb(), e, "mem_ack");
      if (k == K_ST) return;
    end
    e = '0; e.seu_sel = seu_for(k); e.reg_write = 1; e.mem_to_reg = (k == K_LD);
    push(op, rb(), rb(), e, "wb");
  endtask

  task automatic run(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      @(negedge clk);
      opcode = c.op; mem_ack = c.ack; zero = c.z;
      #1;
      chk(c.tag, 64'(dut_o), 64'(c.exp));
    end
  endtask

  function automatic logic [10:0] rand_op();
    logic [10:0] r4 [4];
    r4[0] = ADD; r4[1] = SUB; r4[2] = AND_; r4[3] = ORR;
    case ($urandom_range(0, 7))
      0, 7:    return r4[$urandom_range(0, 3)];
      1:       return {10'b1001000100, rb()};
      2:       return {10'b1101000100, rb()};
      3:       return LDUR;
      4:       return STUR;
      5:       return {6'b000101, 5'($urandom)};
      default: return {8'b10110100, 3'($urandom)};
    endcase
  endfunction

  // Directed per-instruction vectors, ack always immediate.
  // lat = cycles from fetch ack to next fetch; exec fields sampled in cycle 2.
  typedef struct {
    logic [10:0] op;
    logic        z;
    int          lat;
    logic [1:0]  seu;
    logic [1:0]  aop;
    logic        src, r2, pcw, pcs;
    int          nrw;
  } vec_t;

  vec_t tbl [11];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{ADD,                   1'b0, 4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[1]  = '{SUB,                   1'b0, 4, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{AND_,                  1'b0, 4, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[3]  = '{ORR,                   1'b0, 4, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[4]  = '{11'b10010001001,       1'b0, 4, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{11'b11010001000,       1'b0, 4, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{LDUR,                  1'b0, 5, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{STUR,                  1'b0, 4, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[8]  = '{11'b00010100000,       1'b0, 3, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    tbl[9]  = '{11'b10110100101,       1'b1, 3, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 0};
    tbl[10] = '{11'b10110100010,       1'b0, 3, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 0};

    // Reset held 3 cycles with ack high: every output must stay low.
    rst_n = 1'b0; mem_ack = 1'b1; opcode = ADD; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("reset_outs", 64'(dut_o), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    build(ADD, 0, 0);   // first cycle after release: fetch with ack
    run(q.size());

    // Table-driven directed vectors.
    for (int t = 0; t < 11; t++) begin
      int         n, nrw;
      bit         done;
      logic [7:0] ex;
      n = 0; nrw = 0; done = 0; ex = '0;
      while (!done && n < 20) begin
        @(negedge clk);
        opcode = tbl[t].op; zero = tbl[t].z; mem_ack = 1'b1;
        #1;
        if (n == 2) ex = {seu_sel, alu_op, alu_src, reg2_loc, pc_write, pc_src};
        if (reg_write) nrw++;
        if (n > 0 && mem_req && !mem_is_data) begin
          done = 1; mem_ack = 1'b0;   // park in FETCH for the next vector
        end else n++;
      end
      chk($sformatf("lat[%0d]", t), 64'(n), 64'(tbl[t].lat));
      chk($sformatf("exec[%0d]", t), 64'(ex),
          64'({tbl[t].seu, tbl[t].aop, tbl[t].src, tbl[t].r2, tbl[t].pcw, tbl[t].pcs}));
      chk($sformatf("nrw[%0d]", t), 64'(nrw), 64'(tbl[t].nrw));
    end

    // LDUR with data ack 3 cycles late, then STUR with delayed fetch and data.
    build(LDUR, 0, 3);
    build(STUR, 2, 2);
    run(q.size());

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      build(rand_op(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      run(q.size());
    end

    // Reset asserted while LDUR waits on the data port.
    build(LDUR, 0, 5);
    run(5);
    #2;
    rst_n = 1'b0; mem_ack = 1'b1;
    #1;
    chk("mid_mem_reset", 64'(dut_o), 64'd0);
    @(posedge clk); #1;
    chk("mid_mem_reset_edge", 64'(dut_o), 64'd0);
    rst_n = 1'b1;
    q.delete();
    build(STUR, 1, 1);
    run(q.size());

    // Illegal opcode: halted, no requests for 20 cycles, only reset recovers.
    build(11'b00000000000, 0, 0);
    run(q.size());
    #1;
    rst_n = 1'b0;
    #1;
    chk("halt_reset", 64'(dut_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef LEGV8_MC_CTRL_PERF_EN
    chk("retired_reset", 64'(retired), 64'd0);
`endif

    // 17 ADDs after reset; a 4-bit retired counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      build(ADD, int'($urandom_range(0, 1)), 0);
      run(q.size());
    end
    @(posedge clk); #1;
`ifdef LEGV8_MC_CTRL_PERF_EN
    chk("retired_wrap", 64'(retired), 64'd1);
`endif
    chk("fetch_after_adds", 64'({mem_req, mem_is_data, halted}), 64'(3'b100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
